instruction_fetch: RTL
======================

# instruction_fetch

Instruction-cycle sequencer and fetch stage of the PIC16F-compatible core. It divides `clk` into four-phase (Q1–Q4) instruction cycles and reads program memory at the address supplied by the program counter. It presents the prefetched word to the execute stage one instruction cycle later and pulses the program counter's increment enable. It sits between the program counter and program memory upstream, and the decoder/execute stage downstream; it discards the prefetched word when execute redirects the PC, which gives PIC two-cycle branches.

## Interface
Parameters:
- `PC_W`, 13, program address width
- `INSTR_W`, 14, instruction word width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  1 = execute; 0 = sleep/halt, sampled at Q1
- `pc_in`  in  PC_W  current PC, from program counter `pc_out`
- `incr_pc_en`  out  1  one-clk pulse to program counter
- `pmem_rd_en`  out  1  program memory read strobe
- `pmem_addr`  out  PC_W  program memory address
- `pmem_data`  in  INSTR_W  read data, valid the clk after `pmem_rd_en`
- `flush`  in  1  from execute: PC was/is being overwritten this instruction cycle
- `ir_out`  out  INSTR_W  instruction for execute
- `ir_valid`  out  1  0 = bubble (`ir_out` = NOP)
- `ir_load`  out  1  one-clk pulse when `ir_out`/`ir_valid` update
- `q_phase`  out  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4

## Operation
- Phase sequencer runs Q1→Q2→Q3→Q4→Q1, one step per clk.
  - In Q1 with `run`=0: the sequencer holds in Q1, `pmem_rd_en`=0, no increment, IR held.
  - `run` is sampled only in Q1. Deasserting it mid-cycle completes the current instruction cycle.
- Q1 with `run`=1: `pmem_rd_en`=1, `pmem_addr`=`pc_in`. `pmem_addr` is combinational from `pc_in` in all phases; it is only meaningful while `pmem_rd_en`=1.
- Q2: `fetch_buf` ← `pmem_data`. `fetch_buf` is held in all other phases.
- Q3: no action, except flush capture.
- Q4:
  - `incr_pc_en`=1 for exactly this clk.
  - `ir_load`=1.
  - If `flush_pend`|`flush`: `ir_out` ← NOP (14'h0000), `ir_valid` ← 0.
  - Otherwise: `ir_out` ← `fetch_buf`, `ir_valid` ← 1.
  - `flush_pend` is cleared.
- Flush: when `flush`=1 in Q1–Q3, set sticky `flush_pend`. `flush` in Q4 acts directly. Multiple assertions in one instruction cycle behave as one.
- Increment and PC load in the same clk: execute writes the PC in Q4 together with `flush`. Program counter load priority over increment makes the next Q1 fetch the branch target.
- Pipeline: while execute runs the word in `ir_out` during instruction cycle N, the fetch stage fetches the word for N+1. The first instruction cycle after reset is fetch-only, so `ir_valid`=0.

## Timing
- Reset values:
  - `q_phase`=0 (Q1)
  - `incr_pc_en`=0, `ir_load`=0
  - `ir_out`=14'h0000, `ir_valid`=0
  - `fetch_buf`=0, `flush_pend`=0
  - `pmem_rd_en` follows Q1 and `run`; it is 1 in the first clk after reset if `run`=1
- Reset mid-cycle: all state returns to reset values on the next edge. The in-flight fetch and pending flush are discarded, and no `incr_pc_en` is issued.
- Latency: the word at PC `A` read in Q1 (clk t) appears on `ir_out` from clk t+4 for one full instruction cycle.
- `incr_pc_en` asserts at clk t+3, so `pc_in` = A+1 at the next Q1.
- Steady state: one instruction per 4 clks. A flushed slot costs one bubble instruction cycle, for 2 instruction cycles per taken branch.
- PC wrap-around: handled by the program counter. The fetch stage passes `pc_in` unmodified.
- `flush` while `run`=0 hold: ignored. No instruction cycle is in progress.

## Structure
- Shared package `pic_pkg`:
  - `PC_W`, `INSTR_W`
  - `q_phase_t` enum {Q1, Q2, Q3, Q4} = 0..3
  - `INSTR_NOP` = 14'h0000
- Sub-module `q_sequencer`: 2-bit phase counter with `run` gating in Q1. It provides `q_phase` and one-hot phase strobes.
- The fetch buffer, IR, flush tracking and strobes live in the `instruction_fetch` top.

## Test plan
- Reset release, `run`=1, memory[0]=14'h3005, memory[1]=14'h0805, PC model attached:
  - `pmem_rd_en` at clk 0, `pmem_addr`=0
  - `incr_pc_en` at clk 3
  - `ir_out`=14'h3005, `ir_valid`=1 from clk 4
  - `pmem_addr`=1 at clk 4
- Straight-line run of 8 words: `incr_pc_en` pulses exactly every 4th clk, and `ir_out` equals memory[k] in instruction cycle k+1.
- `flush` in Q2 of a cycle with execute loading PC=13'h0100 in Q4:
  - next `ir_out`=0, `ir_valid`=0
  - next Q1 fetches from `pmem_addr`=13'h0100
  - the following cycle has `ir_valid`=1
- `flush` asserted only in Q4: same bubble result. `flush` asserted in Q1 and Q3 of one cycle: exactly one bubble.
- `run`=0 sampled at Q1: `q_phase` stays 0, no `pmem_rd_en`, no `incr_pc_en`, `ir_out` unchanged for 20 clks. `run`=1 resumes with a fetch at the next clk.
- `rst` pulsed in Q3 with `flush_pend` set: next clk `q_phase`=0, `ir_valid`=0, no `incr_pc_en` issued for the aborted cycle.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and widths for the PIC16F-compatible core.
package pic_pkg;

  localparam int unsigned PC_W       = 13;
  localparam int unsigned INSTR_W    = 14;
  localparam int unsigned NUM_PHASES = 4;

  // Instruction-cycle phase; the encoding doubles as the q_phase output value.
  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  localparam logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'(14'h0000);

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program counter, program memory and execute-stage signals.
interface instruction_fetch_if;

  logic [pic_pkg::PC_W-1:0]    pc_in;
  logic                        incr_pc_en;
  logic                        pmem_rd_en;
  logic [pic_pkg::PC_W-1:0]    pmem_addr;
  logic [pic_pkg::INSTR_W-1:0] pmem_data;
  logic                        flush;
  logic [pic_pkg::INSTR_W-1:0] ir_out;
  logic                        ir_valid;
  logic                        ir_load;

  // Fetch stage side.
  modport master (
    input  pc_in,
    input  pmem_data,
    input  flush,
    output incr_pc_en,
    output pmem_rd_en,
    output pmem_addr,
    output ir_out,
    output ir_valid,
    output ir_load
  );

  // Program counter / program memory / execute side.
  modport slave (
    output pc_in,
    output pmem_data,
    output flush,
    input  incr_pc_en,
    input  pmem_rd_en,
    input  pmem_addr,
    input  ir_out,
    input  ir_valid,
    input  ir_load
  );

endinterface

// File: rtl/instruction_fetch_q_sequencer.sv
// Four-phase (Q1..Q4) instruction-cycle sequencer; holds in Q1 while run is low.
module q_sequencer
  import pic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  output q_phase_t              q_phase_o,
  output logic [NUM_PHASES-1:0] q_strb_o
);

  q_phase_t phase_q;
  q_phase_t phase_d;

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= Q1;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase and one-hot phase strobes (bit i set in phase i).
  always_comb begin
    phase_d  = phase_q;
    q_strb_o = '0;
    unique case (phase_q)
      Q1: begin
        q_strb_o = 4'b0001;
        if (run_i) begin
          phase_d = Q2;
        end
      end
      Q2: begin
        q_strb_o = 4'b0010;
        phase_d  = Q3;
      end
      Q3: begin
        q_strb_o = 4'b0100;
        phase_d  = Q4;
      end
      Q4: begin
        q_strb_o = 4'b1000;
        phase_d  = Q1;
      end
      default: begin
        q_strb_o = 4'b0001;
        phase_d  = Q1;
      end
    endcase
  end

  assign q_phase_o = phase_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads program memory in Q1, buffers the word in Q2 and loads
// the IR in Q4, replacing the word with a NOP bubble when execute flushed.
module instruction_fetch
  import pic_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output q_phase_t                   q_phase,
  instruction_fetch_if.master        bus
);

  logic [NUM_PHASES-1:0] q_strb;
  logic                  fetch_c;
  logic                  flush_win_c;
  logic                  q4_c;

  logic [INSTR_W-1:0] fetch_buf_q, fetch_buf_d;
  logic [INSTR_W-1:0] ir_q,        ir_d;
  logic               ir_valid_q,  ir_valid_d;
  logic               flush_pend_q, flush_pend_d;

  q_sequencer u_q_sequencer (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run),
    .q_phase_o (q_phase),
    .q_strb_o  (q_strb)
  );

  // Q1 fetch only starts an instruction cycle when run is high.
  assign fetch_c     = q_strb[0] & run;
  // Window in which a flush is remembered for the Q4 IR load.
  assign flush_win_c = fetch_c | q_strb[1] | q_strb[2];
  // Q4 is suppressed while reset is held so an aborted cycle never increments.
  assign q4_c        = q_strb[3] & ~rst;

  // Fetch buffer, flush tracking and IR next-state.
  always_comb begin
    fetch_buf_d  = fetch_buf_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    flush_pend_d = flush_pend_q;

    if (q_strb[1]) begin
      fetch_buf_d = bus.pmem_data;
    end

    if (flush_win_c && bus.flush) begin
      flush_pend_d = 1'b1;
    end

    if (q_strb[3]) begin
      if (flush_pend_q || bus.flush) begin
        ir_d       = INSTR_NOP;
        ir_valid_d = 1'b0;
      end else begin
        ir_d       = fetch_buf_q;
        ir_valid_d = 1'b1;
      end
      flush_pend_d = 1'b0;
    end
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_buf_q  <= '0;
      ir_q         <= INSTR_NOP;
      ir_valid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      fetch_buf_q  <= fetch_buf_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.pmem_rd_en = fetch_c;
  assign bus.pmem_addr  = bus.pc_in;
  assign bus.incr_pc_en = q4_c;
  assign bus.ir_load    = q4_c;
  assign bus.ir_out     = ir_q;
  assign bus.ir_valid   = ir_valid_q;

endmodule
